pipelined_cla_adder: RTL

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/adder_pkg.sv | 15 +
 rtl/cla_chunk.sv | 41 ++++
 rtl/pipelined_cla_adder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared constants, operation type and chunk-width helper for the pipelined
// carry-lookahead adder.
package adder_pkg;
    localparam int DEFAULT_WIDTH  = 12;
    localparam int DEFAULT_STAGES = 2;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction
endpackage

// File: rtl/cla_chunk.sv
// Combinational CW-bit carry-lookahead chunk: produces the chunk sum, its
// carry-out and the carry into the chunk MSB (used for signed overflow).
module cla_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    input  logic          i_cin,
    output logic [CW-1:0] o_sum,
    output logic          o_cout,
    output logic          o_msb_cin
);
    logic [CW-1:0] w_g;
    logic [CW-1:0] w_p;
    logic [CW:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is a flat sum of products of lower generate/propagate terms,
    // so no carry depends on another carry inside the chunk.
    always_comb begin
        logic w_prop;
        w_prop = 1'b0;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < CW; i++) begin
            w_c[i+1] = w_g[i];
            w_prop   = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_c[i+1] = w_c[i+1] | (w_prop & w_g[j]);
                w_prop   = w_prop & w_p[j];
            end
            w_c[i+1] = w_c[i+1] | (w_prop & i_cin);
        end
    end

    assign o_sum     = w_p ^ w_c[CW-1:0];
    assign o_cout    = w_c[CW];
    assign o_msb_cin = w_c[CW-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Skewed-pipeline carry-lookahead adder/subtractor with valid/ready handshake.
// Defining ADDER_OVF_FLAG_EN adds the registered signed-overflow output out_ovf.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef ADDER_OVF_FLAG_EN
    ,
    output logic             out_ovf
`endif
);
    localparam int CW  = chunk_width(WIDTH, STAGES);
    localparam int NUP = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int UW  = (STAGES > 1) ? WIDTH - CW : 1;

    if (WIDTH < 4 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $fatal(1, "pipelined_cla_adder: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    op_e               w_op;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_c0;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_seg_in_valid;
    logic [CW-1:0]     w_chunk_a   [STAGES];
    logic [CW-1:0]     w_chunk_b   [STAGES];
    logic [CW-1:0]     w_chunk_sum [STAGES];
    logic [STAGES-1:0] w_chunk_cin;
    logic [STAGES-1:0] w_chunk_cout;
    logic [STAGES-1:0] w_chunk_msbc;
    logic [WIDTH-1:0]  w_sum_in    [STAGES];
    logic [UW-1:0]     w_up_a_in   [NUP];
    logic [UW-1:0]     w_up_b_in   [NUP];

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic [WIDTH-1:0]  r_sum  [STAGES];
    logic [UW-1:0]     r_up_a [NUP];
    logic [UW-1:0]     r_up_b [NUP];

    // Subtraction is folded in at the input: invert b and the borrow once.
    assign w_op    = op_e'(in_sub);
    assign w_b_eff = (w_op == OP_SUB) ? ~in_b : in_b;
    assign w_c0    = (w_op == OP_SUB) ? ~in_cin : in_cin;

    always_comb begin
        w_adv          = '0;
        w_seg_in_valid = '0;
        w_adv[STAGES-1] = !r_valid[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = !r_valid[k] | w_adv[k+1];
        end
        w_seg_in_valid[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_seg_in_valid[k] = r_valid[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        if (k == 0) begin : g_first
            assign w_chunk_a[k]   = in_a[CW-1:0];
            assign w_chunk_b[k]   = w_b_eff[CW-1:0];
            assign w_chunk_cin[k] = w_c0;
            assign w_sum_in[k]    = WIDTH'(w_chunk_sum[k]);
        end else begin : g_rest
            assign w_chunk_a[k]   = r_up_a[k-1][(k-1)*CW +: CW];
            assign w_chunk_b[k]   = r_up_b[k-1][(k-1)*CW +: CW];
            assign w_chunk_cin[k] = r_carry[k-1];
            // bits at and above chunk k are still zero in the previous segment
            assign w_sum_in[k]    = r_sum[k-1] | (WIDTH'(w_chunk_sum[k]) << (k * CW));
        end

        cla_chunk #(.CW(CW)) u_chunk (
            .i_a       (w_chunk_a[k]),
            .i_b       (w_chunk_b[k]),
            .i_cin     (w_chunk_cin[k]),
            .o_sum     (w_chunk_sum[k]),
            .o_cout    (w_chunk_cout[k]),
            .o_msb_cin (w_chunk_msbc[k])
        );
    end

    if (STAGES > 1) begin : g_up
        for (genvar k = 0; k < STAGES - 1; k++) begin : g_up_seg
            if (k == 0) begin : g_first
                assign w_up_a_in[k] = in_a[WIDTH-1:CW];
                assign w_up_b_in[k] = w_b_eff[WIDTH-1:CW];
            end else begin : g_rest
                assign w_up_a_in[k] = r_up_a[k-1];
                assign w_up_b_in[k] = r_up_b[k-1];
            end
        end
    end else begin : g_no_up
        assign w_up_a_in[0] = '0;
        assign w_up_b_in[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_carry <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= '0;
            end
            for (int k = 0; k < NUP; k++) begin
                r_up_a[k] <= '0;
                r_up_b[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= w_seg_in_valid[k];
                    if (w_seg_in_valid[k]) begin
                        r_carry[k] <= w_chunk_cout[k];
                        r_sum[k]   <= w_sum_in[k];
                    end
                end
            end
            for (int k = 0; k < NUP; k++) begin
                if (w_adv[k] && w_seg_in_valid[k]) begin
                    r_up_a[k] <= w_up_a_in[k];
                    r_up_b[k] <= w_up_b_in[k];
                end
            end
        end
    end

`ifdef ADDER_OVF_FLAG_EN
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv[STAGES-1] && w_seg_in_valid[STAGES-1]) begin
            r_ovf <= w_chunk_msbc[STAGES-1] ^ w_chunk_cout[STAGES-1];
        end
    end

    assign out_ovf = r_ovf;
`endif

    // Only the top chunk's MSB carry-in matters, and only for overflow.
    logic w_unused_msbc;
    assign w_unused_msbc = ^w_chunk_msbc;

    assign in_ready  = !r_valid[0] | w_adv[0];
    assign out_valid = r_valid[STAGES-1];
    assign out_sum   = r_sum[STAGES-1];
    assign out_cout  = r_carry[STAGES-1];
endmodule
